// File: rtl/i2c_pkg.sv
// Shared definitions for the AXI-Stream to I2C command front end:
// parser FSM state encodings and the position of the R/W bit in the header beat.
package i2c_pkg;

  typedef enum logic [1:0] {
    StHdr  = 2'd0,
    StData = 2'd1,
    StDrop = 2'd2
  } state_e;

  // R/W bit sits this many positions below the MSB of the header beat.
  localparam int unsigned RwBitFromMsb = 0;

  // Absolute R/W bit index for a given beat width.
  function automatic int unsigned rw_bit_pos(input int unsigned data_width);
    return data_width - 1 - RwBitFromMsb;
  endfunction

endpackage

// File: rtl/axis_i2c_cmd.sv
// AXI-Stream front end for the I2C write master.
// Beat 0 of a frame is the header {R/W, addr}; each following beat becomes one
// {data, addr} push into the master's command FIFO. Read frames are consumed
// and discarded. A push is never issued into a full FIFO: acceptance in DATA is
// blocked while fifo_full is high and during the push cycle itself, so the
// FIFO's registered full flag has settled before the next beat is taken.
// Optional feature: define AXIS_I2C_DROP_CNT_EN to add an 8-bit saturating
// count of rejected read frames on output drop_cnt.
module axis_i2c_cmd
  import i2c_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full
`ifdef AXIS_I2C_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int unsigned RwBit = rw_bit_pos(DATA_WIDTH);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_lat_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_en_q;
  logic                  hs;
  logic                  hdr_is_read;

  assign data        = data_q;
  assign addr        = addr_q;
  assign fifo_wr_en  = wr_en_q;
  assign hs          = s_axis_tvalid & s_axis_tready;
  assign hdr_is_read = s_axis_tdata[RwBit];

  // Ready depends only on state and FIFO back-pressure, never on tvalid.
  always_comb begin
    s_axis_tready = 1'b0;
    unique case (state_q)
      StHdr:   s_axis_tready = 1'b1;
      StData:  s_axis_tready = ~fifo_full & ~wr_en_q;
      StDrop:  s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  // Frame parser FSM with registered command outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= StHdr;
      addr_lat_q <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        StHdr: begin
          // A header carrying tlast is an empty or lone-read frame: drop it.
          if (hs && !s_axis_tlast) begin
            if (hdr_is_read) begin
              state_q <= StDrop;
            end else begin
              addr_lat_q <= s_axis_tdata[ADDR_WIDTH-1:0];
              state_q    <= StData;
            end
          end
        end
        StData: begin
          if (hs) begin
            data_q  <= s_axis_tdata;
            addr_q  <= addr_lat_q;
            wr_en_q <= 1'b1;
            if (s_axis_tlast) begin
              state_q <= StHdr;
            end
          end
        end
        StDrop: begin
          if (hs && s_axis_tlast) begin
            state_q <= StHdr;
          end
        end
        default: state_q <= StHdr;
      endcase
    end
  end

`ifdef AXIS_I2C_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  assign drop_cnt = drop_cnt_q;

  // Count read headers at acceptance, lone-read headers included; saturate at 255.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      drop_cnt_q <= 8'd0;
    end else if (state_q == StHdr && hs && hdr_is_read && drop_cnt_q != 8'hff) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_i2c_cmd.sv
// Self-checking bench for axis_i2c_cmd. Frames are described as byte lists;
// the reference model derives the expected command stream and drop count
// straight from the frame format, and a monitor scores every push.
module tb_axis_i2c_cmd;

  typedef struct packed {
    logic [7:0] d;
    logic [6:0] a;
  } cmd_t;

  logic       clk = 1'b0;
  logic       arst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic [7:0] data;
  logic [6:0] addr;
  logic       fifo_wr_en;
  logic       fifo_full;
`ifdef AXIS_I2C_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  cmd_t exp_q[$];
  int   cyc = 0;
  int   last_push = -100;
  int   prev_push = -100;
  int   n_push = 0;
  logic full_prev = 1'b0;
  bit   rand_full = 1'b0;
  int   drop_model = 0;
  logic [7:0] frame [16];
  int   frame_len;
  int   frame_waits;

  axis_i2c_cmd #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(7)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .data         (data),
    .addr         (addr),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_full    (fifo_full)
`ifdef AXIS_I2C_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Push scoreboard: content, never after a full cycle, at most one per 2 cycles.
  initial begin
    cmd_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (fifo_wr_en === 1'b1 && arst === 1'b0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_push: got data=%02h addr=%02h, expected no push", data, addr);
        end else begin
          e = exp_q.pop_front();
          if (data !== e.d || addr !== e.a) begin
            n_err++;
            $display("FAIL push_content: got data=%02h addr=%02h, expected data=%02h addr=%02h",
                     data, addr, e.d, e.a);
          end
        end
        n_cmp++;
        if (full_prev !== 1'b0) begin
          n_err++;
          $display("FAIL push_into_full: push followed a cycle with fifo_full=%b, expected 0",
                   full_prev);
        end
        n_cmp++;
        if (cyc - last_push < 2) begin
          n_err++;
          $display("FAIL push_gap: got %0d cycles between pushes, expected >= 2", cyc - last_push);
        end
        prev_push = last_push;
        last_push = cyc;
        n_push++;
      end
      full_prev = fifo_full;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_full) fifo_full = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send_beat(input logic [7:0] b, input logic last, output int waits);
    bit acc;
    acc = 1'b0;
    waits = 0;
    s_axis_tdata  = b;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk);
      acc = s_axis_tready;
      tick();
      if (!acc) waits++;
    end
    s_axis_tvalid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_timeout: beat %02h not accepted in 500 cycles, expected acceptance", b);
    end
  endtask

  // Model: a write header with N data beats yields N commands {byte, header addr};
  // a read header (lone or not) bumps the saturating drop count.
  task automatic send_frame(input bit idle);
    int w;
    if (frame[0][7]) begin
      drop_model = (drop_model < 255) ? drop_model + 1 : 255;
    end else begin
      for (int i = 1; i < frame_len; i++) exp_q.push_back({frame[i], frame[0][6:0]});
    end
    frame_waits = 0;
    for (int i = 0; i < frame_len; i++) begin
      send_beat(frame[i], (i == frame_len - 1), w);
      frame_waits += w;
      if (idle) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic check_drop(input string name);
`ifdef AXIS_I2C_DROP_CNT_EN
    n_cmp++;
    if (drop_cnt !== drop_model[7:0]) begin
      n_err++;
      $display("FAIL %s: drop_cnt got %0d, expected %0d", name, drop_cnt, drop_model);
    end
`endif
  endtask

  task automatic test_reset();
    arst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = 8'h00;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (data !== 8'h00 || addr !== 7'h00 || fifo_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%02h addr=%02h wr_en=%b, expected 00 00 0",
               data, addr, fifo_wr_en);
    end
    n_cmp++;
    if (s_axis_tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_tready: got %b, expected 1 (header state)", s_axis_tready);
    end
    check_drop("reset_drop_cnt");
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  task automatic test_basic_frame();
    int np0;
    np0 = n_push;
    frame[0] = 8'h50; frame[1] = 8'hA1; frame[2] = 8'hB2; frame_len = 3;
    send_frame(1'b0);
    @(negedge clk);
    n_cmp++;
    if (s_axis_tready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_back_to_hdr: tready got %b, expected 1", s_axis_tready);
    end
    repeat (4) tick();
    n_cmp++;
    if (n_push != np0 + 2 || last_push - prev_push != 2) begin
      n_err++;
      $display("FAIL basic_pushes: got %0d pushes gap %0d, expected 2 pushes gap 2",
               n_push - np0, last_push - prev_push);
    end
  endtask

  task automatic test_read_drop();
    int np0;
    np0 = n_push;
    frame[0] = 8'hD0; frame[1] = 8'h11; frame_len = 2;
    send_frame(1'b0);
    repeat (4) tick();
    n_cmp++;
    if (frame_waits != 0 || n_push != np0) begin
      n_err++;
      $display("FAIL read_drop: got waits=%0d pushes=%0d, expected waits=0 pushes=0",
               frame_waits, n_push - np0);
    end
    check_drop("read_drop_cnt");
  endtask

  task automatic test_full_backpressure();
    int w;
    int np0;
    rand_full = 1'b0;
    fifo_full = 1'b0;
    send_beat(8'h50, 1'b0, w);
    fifo_full = 1'b1;
    exp_q.push_back({8'hC3, 7'h50});
    np0 = n_push;
    s_axis_tdata = 8'hC3;
    s_axis_tlast = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (s_axis_tready !== 1'b0) begin
        n_err++;
        $display("FAIL full_hold_tready: cycle %0d got %b, expected 0", i, s_axis_tready);
      end
      @(posedge clk);
      #1;
    end
    fifo_full = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_axis_tready !== 1'b1 || n_push != np0) begin
      n_err++;
      $display("FAIL full_release: got tready=%b pushes=%0d, expected tready=1 pushes=0",
               s_axis_tready, n_push - np0);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fifo_wr_en !== 1'b1) begin
      n_err++;
      $display("FAIL full_push_latency: wr_en got %b, expected 1", fifo_wr_en);
    end
    repeat (2) tick();
  endtask

  task automatic test_lone_header();
    int np0;
    np0 = n_push;
    frame[0] = 8'h2A; frame_len = 1;
    send_frame(1'b0);
    repeat (3) tick();
    n_cmp++;
    if (n_push != np0) begin
      n_err++;
      $display("FAIL lone_header: got %0d pushes, expected 0", n_push - np0);
    end
    frame[0] = 8'h2B; frame[1] = 8'h77; frame_len = 2;
    send_frame(1'b0);
    repeat (3) tick();
    n_cmp++;
    if (n_push != np0 + 1) begin
      n_err++;
      $display("FAIL lone_next_frame: got %0d pushes, expected 1", n_push - np0);
    end
  endtask

  task automatic test_arst_midframe();
    int w;
    int np0;
    np0 = n_push;
    exp_q.push_back({8'hD1, 7'h10});
    exp_q.push_back({8'hD2, 7'h10});
    send_beat(8'h10, 1'b0, w);
    send_beat(8'hD1, 1'b0, w);
    send_beat(8'hD2, 1'b0, w);
    @(negedge clk);
    #1;
    arst = 1'b1;
    #1;
    n_cmp++;
    if (data !== 8'h00 || addr !== 7'h00 || fifo_wr_en !== 1'b0 || s_axis_tready !== 1'b1) begin
      n_err++;
      $display("FAIL arst_outputs: got data=%02h addr=%02h wr_en=%b tready=%b, expected 00 00 0 1",
               data, addr, fifo_wr_en, s_axis_tready);
    end
    @(posedge clk);
    #1;
    arst = 1'b0;
    // Leftover tlast beat of the abandoned frame is now a lone header.
    frame[0] = 8'h33; frame_len = 1;
    send_frame(1'b0);
    frame[0] = 8'h2C; frame[1] = 8'h99; frame_len = 2;
    send_frame(1'b0);
    repeat (3) tick();
    n_cmp++;
    if (n_push != np0 + 3) begin
      n_err++;
      $display("FAIL arst_pushes: got %0d pushes, expected 3", n_push - np0);
    end
  endtask

  task automatic test_random();
    rand_full = 1'b1;
    for (int f = 0; f < 60; f++) begin
      frame_len = $urandom_range(1, 5);
      for (int i = 0; i < frame_len; i++) frame[i] = 8'($urandom);
      send_frame(1'b1);
    end
    rand_full = 1'b0;
    fifo_full = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL random_drain: got %0d missing pushes, expected 0", exp_q.size());
    end
    check_drop("random_drop_cnt");
  endtask

  task automatic test_drop_saturate();
`ifdef AXIS_I2C_DROP_CNT_EN
    for (int f = 0; f < 300; f++) begin
      frame_len = $urandom_range(1, 2);
      frame[0] = 8'h80 | 8'($urandom);
      frame[1] = 8'($urandom);
      send_frame(1'b0);
    end
    repeat (3) tick();
    n_cmp++;
    if (drop_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL drop_saturate: drop_cnt got %0d, expected 255", drop_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_read_drop();
    test_full_backpressure();
    test_lone_header();
    test_arst_midframe();
    test_random();
    test_drop_saturate();
    repeat (4) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL final_drain: got %0d missing pushes, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
